// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and helpers for the FIR output requantiser.
//   Y_N_SIZE_D / OUT_SIZE_D : default input / output sample widths
//   SAT_MAX / SAT_MIN       : clamp limits of a signed OUT_SIZE_D sample
//   sat_round()             : rounding right-shift followed by saturation
package fir_pkg;

  localparam int Y_N_SIZE_D = 14;
  localparam int OUT_SIZE_D = 8;
  localparam int SAT_MAX    = (2 ** (OUT_SIZE_D - 1)) - 1;
  localparam int SAT_MIN    = -(2 ** (OUT_SIZE_D - 1));

  // Shift right by 'shift' rounding half toward +inf, then clamp to a signed
  // out_size-bit range. With shift=0 this is a pure clamp.
  function automatic int sat_round(input int value, input int shift,
                                   input int out_size = OUT_SIZE_D);
    int t;
    int hi;
    int lo;
    t  = (shift > 0) ? ((value + (1 << (shift - 1))) >>> shift) : value;
    hi = (1 << (out_size - 1)) - 1;
    lo = -(1 << (out_size - 1));
    if (t > hi)      t = hi;
    else if (t < lo) t = lo;
    return t;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: synchronous first-word-fall-through FIFO.
//   push/push_data : write request; accepted when not full, or when full and
//                    a pop happens on the same edge
//   pop            : remove head; ignored while empty
//   pop_data       : head entry, 0 while empty
//   full/empty     : occupancy status
//   level          : occupancy 0..DEPTH
//   drop           : push rejected this cycle (full, no pop)
module fir_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (cnt == '0);
  assign full     = (cnt == LW'(DEPTH));
  assign pop_ok   = pop && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok  = push && (!full || pop_ok);
  assign drop     = push && !push_ok;
  assign pop_data = empty ? '0 : mem[rd_ptr];
  assign level    = cnt;

  // Storage needs no reset: contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// fir_out_requant: FIR output requantiser.
//   y_n/y_valid/shift : filter output, its strobe and the rounding shift
//   m_tdata/m_tvalid  : FWFT stream of saturated OUT_SIZE-bit samples
//   m_tready          : consumer pop
//   level             : FIFO occupancy
//   sat_flag/ovf_flag : sticky clip / drop indicators, cleared by clr_flags
// Stage 1 registers the rounded shift, stage 2 clamps and pushes.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter  int Y_N_SIZE   = Y_N_SIZE_D,
  parameter  int OUT_SIZE   = OUT_SIZE_D,
  parameter  int SHIFT_W    = 3,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Y_N_SIZE-1:0] y_n,
  input  logic                y_valid,
  input  logic [SHIFT_W-1:0]  shift,
  output logic [OUT_SIZE-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [LVL_W-1:0]    level,
  output logic                sat_flag,
  output logic                ovf_flag,
  input  logic                clr_flags
);

  // One guard bit so y_n + rnd cannot wrap.
  localparam int RW = Y_N_SIZE + 1;

  logic signed [RW-1:0] y_ext;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] r;
  logic                 v1;

  always_comb begin
    y_ext = {y_n[Y_N_SIZE-1], y_n};
    rnd   = '0;
    if (shift != '0) rnd[shift - SHIFT_W'(1)] = 1'b1;
    sum   = y_ext + rnd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      r  <= '0;
    end else begin
      v1 <= y_valid;
      if (y_valid) r <= sum >>> shift;
    end
  end

  // Stage 2: clamp (sat_round with shift 0 is a pure clamp).
  int                  r_int;
  int                  sat_int;
  logic                clipped;
  logic [OUT_SIZE-1:0] sample;

  always_comb begin
    r_int   = int'(r);
    sat_int = sat_round(r_int, 0, OUT_SIZE);
    clipped = (sat_int != r_int);
    sample  = sat_int[OUT_SIZE-1:0];
  end

  logic full;
  logic empty;
  logic drop;

  fir_sync_fifo #(
    .WIDTH (OUT_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (v1),
    .push_data (sample),
    .pop       (m_tready),
    .pop_data  (m_tdata),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .drop      (drop)
  );

  assign m_tvalid = !empty;

  // Later assignments win, so a set on the same edge overrides a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (clr_flags) begin
        sat_flag <= 1'b0;
        ovf_flag <= 1'b0;
      end
      if (v1 && clipped) sat_flag <= 1'b1;
      if (drop)          ovf_flag <= 1'b1;
    end
  end

endmodule
